// File: rtl/serial_capture.sv
// serial_capture
// Serial-to-parallel receiver and checker for a 1-bit data stream.
// A start strobe opens a frame. The next WIDTH qualified bits are then
// assembled MSB-first. A completed word is presented with a one-cycle
// valid pulse and a comparison flag against a fixed reference pattern.
// A frame that is restarted, or that stalls for TIMEOUT consecutive
// unqualified cycles, is aborted and flagged with a one-cycle error pulse.
//
// Ports:
//   clk        : system clock, rising-edge active
//   rst        : synchronous active-high reset; has priority over all inputs
//   start      : frame start strobe; restarts the frame if one is in progress
//   d_in       : serial data bit
//   d_valid    : d_in qualifier
//   word_out   : last completed frame, MSB = first bit received
//   word_valid : one-cycle pulse when word_out is updated
//   match      : word_out == PATTERN; updated together with word_out
//   busy       : high while a frame is being shifted in
//   err        : one-cycle pulse when a frame is aborted (restart or timeout)
module serial_capture #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = 8'hB1,
  parameter int               TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             d_in,
  input  logic             d_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             match,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  // The gap that brings the count up to TIMEOUT is the one that aborts.
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  // Only WIDTH-1 bits are kept: the final bit goes straight into word_out.
  logic [WIDTH-2:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [WIDTH-1:0] next_word;

  // Saturating gap increment; it never wraps, even if the abort were missed.
  function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] g);
    if (g >= GAP_MAX) begin
      return GAP_MAX;
    end
    return g + GAP_W'(1);
  endfunction

  assign next_word = {shreg, d_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      match      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          // Data in the start cycle is ignored. Data with no start is ignored.
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            // Restart wins over everything, including a final bit.
            err     <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end else if (d_valid) begin
            gap_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              word_out   <= next_word;
              match      <= (next_word == PATTERN);
              word_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
              bit_cnt    <= '0;
            end else begin
              shreg   <= next_word[WIDTH-2:0];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (gap_cnt == GAP_LIMIT) begin
            // Stalled too long: abort. word_out and match keep their values.
            err     <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_inc(gap_cnt);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_capture.sv
// Testbench for serial_capture. Stimulus drives a frame-level reference
// model (a queue of received bits plus a stall counter). The model pushes
// expected word/error events into a scoreboard queue. A separate monitor
// pops an entry whenever the DUT raises word_valid or err. The monitor
// also checks busy, word_out and match against the model on every cycle.
module tb_serial_capture;

  localparam int         W    = 8;
  localparam logic [7:0] PAT  = 8'hB1;
  localparam int         TOUT = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         d_in = 1'b0;
  logic         d_valid = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         match;
  logic         busy;
  logic         err;

  serial_capture #(.WIDTH(W), .PATTERN(PAT), .TIMEOUT(TOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .d_in       (d_in),
    .d_valid    (d_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .match      (match),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] word;
    bit         m;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model state, at the level of frames.
  bit         in_frame = 1'b0;
  bit         bits_q[$];
  int         gap = 0;
  logic [7:0] exp_word = '0;
  bit         exp_match = 1'b0;
  bit         exp_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input bit is_err, input logic [7:0] w, input bit m);
    ev_t e;
    e.is_err = is_err;
    e.word   = w;
    e.m      = m;
    e.cyc    = cyc;
    exp_q.push_back(e);
  endtask

  // Expected outcome of one sampled clock edge, derived from the frame rules.
  task automatic model(input bit r, input bit s, input bit v, input bit d);
    logic [7:0] w;
    if (r) begin
      in_frame = 1'b0;
      bits_q.delete();
      gap = 0;
      exp_word = '0;
      exp_match = 1'b0;
    end else if (!in_frame) begin
      if (s) begin
        in_frame = 1'b1;
        bits_q.delete();
        gap = 0;
      end
    end else if (s) begin
      push_ev(1'b1, exp_word, exp_match);
      bits_q.delete();
      gap = 0;
    end else if (v) begin
      bits_q.push_back(d);
      gap = 0;
      if (bits_q.size() == W) begin
        w = '0;
        foreach (bits_q[i]) w = {w[6:0], bits_q[i]};
        exp_word  = w;
        exp_match = (w == PAT);
        push_ev(1'b0, w, exp_match);
        in_frame = 1'b0;
        bits_q.delete();
      end
    end else begin
      gap++;
      if (gap == TOUT) begin
        push_ev(1'b1, exp_word, exp_match);
        in_frame = 1'b0;
        gap = 0;
      end
    end
    exp_busy = in_frame;
  endtask

  // One clock: drive inputs, let the edge sample them, then update the model.
  task automatic step(input bit r, input bit s, input bit v, input bit d);
    rst = r;
    start = s;
    d_valid = v;
    d_in = d;
    @(posedge clk);
    #1;
    cyc++;
    model(r, s, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Start strobe (with random ignored data), then the word MSB-first with gaps.
  task automatic send_frame(input logic [7:0] w, input int gaps);
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = W - 1; i >= 0; i--) begin
      for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0, 1'b1, w[i]);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (word_valid && err) chk("valid_err_overlap", 32'(word_valid & err), 32'd0);
      if (word_valid === 1'b1 || err === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, err, word_valid}, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", 32'(err), 32'(e.is_err));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.is_err) begin
            chk("word_out", 32'(word_out), 32'(e.word));
            chk("match", 32'(match), 32'(e.m));
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_event", 32'(exp_q[0].cyc), 32'hFFFF_FFFF);
        void'(exp_q.pop_front());
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("held_word", 32'(word_out), 32'(exp_word));
      chk("held_match", 32'(match), 32'(exp_match));
    end
  end

  initial begin
    // 1: reset with start and d_valid driven; nothing may be captured.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(2);

    // 2: contiguous frame of the pattern.
    send_frame(8'hB1, 0);
    idle(2);

    // 3: frame with three stall cycles between bits.
    send_frame(8'h5A, 3);
    idle(2);

    // 4: restart after four bits, then a frame of ones.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // 5: three bits, then a stall long enough to time out; stray data after.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    idle(TOUT);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_word", 32'(word_out), 32'hFF);
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // 6: reset mid-frame with start, then a clean frame.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_word", 32'(word_out), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    send_frame(8'hB1, 1);

    // Back-to-back: start in the word_valid cycle; restart on the final bit.
    send_frame(8'h3C, 0);
    send_frame(8'hC3, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(TOUT + 2);

    // Random traffic with alternating dense and sparse data phases.
    for (int i = 0; i < 1200; i++) begin
      int dvp;
      dvp = ((i / 150) % 2 == 1) ? 8 : 75;
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 99) < dvp), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), $urandom_range(0, 2));
    idle(TOUT + 4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
